fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction-fetch stage that sits directly upstream of instruction_memory.
- Owns the program counter and drives the memory's word-aligned fetch address.
- Captures the returned instruction into an IF/ID pipeline register with valid, PC and PC+4.
- Honours decode stall and execute redirect (branch/jump) requests; redirect flushes the fetched slot.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
IMEM_WORDS, 256, instruction memory depth in 32-bit words; fetch range is 0 .. IMEM_WORDS*4-1
NOP_INSTR, 32'h0000_0033, bubble encoding (ADD x0,x0,x0) placed in IF/ID when invalid

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
stall_i  in  1  hold PC and IF/ID this cycle
redirect_valid_i  in  1  load PC from redirect_target_i and flush IF/ID
redirect_target_i  in  32  branch/jump target; bits [1:0] ignored
imem_addr_o  out  32  fetch address to instruction memory (= current PC)
imem_instr_i  in  32  combinational instruction read from instruction memory
id_valid_o  out  1  IF/ID slot holds a real instruction
id_instr_o  out  32  IF/ID instruction
id_pc_o  out  32  PC of id_instr_o
id_pc_plus4_o  out  32  id_pc_o + 4, modulo 2^32
fetch_fault_o  out  1  IF/ID slot was fetched from PC >= IMEM_WORDS*4 (registered with slot)

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: PC=RESET_PC; id_valid_o=0; id_instr_o=NOP_INSTR; id_pc_o=0; id_pc_plus4_o=0; fetch_fault_o=0.
- imem_addr_o = PC register, combinational, no added latency. Instruction memory is asynchronous, so fetch-to-IF/ID latency is one cycle.
- Per rising edge, in priority order:
  1. redirect_valid_i=1: PC<={redirect_target_i[31:2],2'b00}; id_valid_o<=0; id_instr_o<=NOP_INSTR; fetch_fault_o<=0. Redirect overrides stall_i.
  2. stall_i=1: PC and all IF/ID outputs hold.
  3. Normal advance: PC<=PC+4 (wraps 0xFFFF_FFFC -> 0x0000_0000); id_pc_o<=PC; id_pc_plus4_o<=PC+4.
     - If PC < IMEM_WORDS*4: id_instr_o<=imem_instr_i, id_valid_o<=1, fetch_fault_o<=0.
     - Otherwise: id_instr_o<=NOP_INSTR, id_valid_o<=0, fetch_fault_o<=1; PC still advances.
- First edge after reset release captures the instruction at RESET_PC with id_valid_o=1, provided stall_i and redirect_valid_i are both 0.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronously), regardless of stall_i or redirect_valid_i.
- No internal FSM beyond the PC and IF/ID registers; arithmetic is 32-bit unsigned with wrap.

Optional Feature:
Macro FETCH_PERF_EN.
- Defined: adds outputs perf_fetch_count_o[31:0] and perf_stall_count_o[31:0].
  - perf_fetch_count_o increments on each edge that loads id_valid_o=1.
  - perf_stall_count_o increments on each edge where stall_i=1 and redirect_valid_i=0.
  - Both counters reset to 0 and wrap at 2^32.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package riscv_pkg holds: XLEN=32, NOP_INSTR constant, and the packed struct if_id_t {valid, fault, instr, pc, pc_plus4}.
- One sub-module, fetch_if_id_reg: holds if_id_t with async reset, load / hold / flush controls.
- PC register and next-PC logic stay in fetch_stage.

Test Plan:
- Reset release, no stall, imem returns memory[pc>>2] -> cycle 1: id_pc_o=0x0, id_valid_o=1; cycle 2: id_pc_o=0x4; id_instr_o=0x001080B3 at id_pc_o=0x4.
- stall_i=1 for 3 cycles at PC=0x0C -> imem_addr_o stays 0x0C, IF/ID holds; release -> id_pc_o=0x0C next edge.
- redirect_valid_i=1, target 0x23, stall_i=1 same cycle -> PC=0x20, id_valid_o=0, id_instr_o=0x00000033; next edge id_pc_o=0x20, id_valid_o=1.
- Redirect to 0x3FC, then advance twice -> slot for 0x3FC valid; slot for 0x400 has id_valid_o=0, fetch_fault_o=1, NOP_INSTR.
- Redirect to 0xFFFF_FFFC, advance -> id_pc_plus4_o=0x0, PC=0x0; fetch_fault_o=1.
- rst pulsed asynchronously between edges mid-run -> all outputs immediately at reset values; with FETCH_PERF_EN, both counters read 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the fetch front end.
//   XLEN      : machine word width
//   NOP_INSTR : bubble encoding (ADD x0,x0,x0) placed in an empty IF/ID slot
//   if_id_t   : IF/ID pipeline slot {valid, fault, instr, pc, pc_plus4}
// ---------------------------------------------------------------------------
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0033;

    typedef struct packed {
        logic            valid;
        logic            fault;
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
    } if_id_t;

endpackage

// File: rtl/fetch_if_id_reg.sv
// ---------------------------------------------------------------------------
// fetch_if_id_reg
// IF/ID pipeline slot register with asynchronous active-high reset.
// Ports:
//   clk, rst : clock (rising edge), asynchronous active-high reset
//   flush    : empty the slot (valid/fault cleared, instr = bubble);
//              the PC fields keep their last value
//   load     : capture d (ignored while flush is high)
//   d        : next slot contents
//   q        : current slot contents
// With neither flush nor load the slot holds.
// ---------------------------------------------------------------------------
module fetch_if_id_reg
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   flush,
    input  logic   load,
    input  if_id_t d,
    output if_id_t q
);

    if_id_t slot_p1;

    // ---- IF/ID boundary ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_p1.valid    <= 1'b0;
            slot_p1.fault    <= 1'b0;
            slot_p1.instr    <= NOP_INSTR;
            slot_p1.pc       <= '0;
            slot_p1.pc_plus4 <= '0;
        end else if (flush) begin
            slot_p1.valid <= 1'b0;
            slot_p1.fault <= 1'b0;
            slot_p1.instr <= NOP_INSTR;
        end else if (load) begin
            slot_p1 <= d;
        end
    end

    assign q = slot_p1;

endmodule

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage: owns the PC, drives the word-aligned fetch address
// to an asynchronous instruction memory and captures the returned word into
// the IF/ID slot one cycle later.
// Ports:
//   clk, rst           : clock (rising edge), asynchronous active-high reset
//   stall_i            : hold PC and IF/ID
//   redirect_valid_i   : load PC from redirect_target_i, flush IF/ID
//                        (wins over stall_i)
//   redirect_target_i  : branch/jump target, bits [1:0] ignored
//   imem_addr_o        : fetch address (= PC)
//   imem_instr_i       : combinational instruction read data
//   id_valid_o, id_instr_o, id_pc_o, id_pc_plus4_o, fetch_fault_o : IF/ID slot
// Optional build macro FETCH_PERF_EN adds perf_fetch_count_o (valid slots
// loaded) and perf_stall_count_o (stalled edges without redirect).
// ---------------------------------------------------------------------------
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned     IMEM_WORDS = 256,
    parameter logic [XLEN-1:0] NOP_INSTR  = riscv_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_target_i,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic [XLEN-1:0] imem_instr_i,
    output logic            id_valid_o,
    output logic [XLEN-1:0] id_instr_o,
    output logic [XLEN-1:0] id_pc_o,
    output logic [XLEN-1:0] id_pc_plus4_o,
`ifdef FETCH_PERF_EN
    output logic [XLEN-1:0] perf_fetch_count_o,
    output logic [XLEN-1:0] perf_stall_count_o,
`endif
    output logic            fetch_fault_o
);

    // Byte limit kept one bit wider so IMEM_WORDS*4 cannot overflow.
    localparam logic [XLEN:0] IMEM_BYTES = (XLEN+1)'(IMEM_WORDS) << 2;

    logic [XLEN-1:0] pc_p0;
    logic [XLEN-1:0] pc_plus4_p0;
    logic [XLEN-1:0] pc_next;
    logic            in_range_p0;
    logic            advance;
    if_id_t          slot_d;
    if_id_t          slot_q;
    logic            unused_tgt_lo;

    assign unused_tgt_lo = ^redirect_target_i[1:0];

    assign pc_plus4_p0 = pc_p0 + 32'd4;
    assign in_range_p0 = ({1'b0, pc_p0} < IMEM_BYTES);
    assign advance     = !redirect_valid_i && !stall_i;
    assign imem_addr_o = pc_p0;

    always_comb begin
        pc_next = pc_p0;
        if (redirect_valid_i) begin
            pc_next = {redirect_target_i[XLEN-1:2], 2'b00};
        end else if (!stall_i) begin
            pc_next = pc_plus4_p0;
        end
    end

    // ---- PC (fetch) boundary ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_p0 <= RESET_PC;
        end else begin
            pc_p0 <= pc_next;
        end
    end

    // Out-of-range fetches still occupy a slot, but as a faulting bubble.
    always_comb begin
        slot_d.valid    = in_range_p0;
        slot_d.fault    = !in_range_p0;
        slot_d.instr    = in_range_p0 ? imem_instr_i : NOP_INSTR;
        slot_d.pc       = pc_p0;
        slot_d.pc_plus4 = pc_plus4_p0;
    end

    fetch_if_id_reg #(
        .NOP_INSTR(NOP_INSTR)
    ) u_if_id (
        .clk  (clk),
        .rst  (rst),
        .flush(redirect_valid_i),
        .load (!stall_i),
        .d    (slot_d),
        .q    (slot_q)
    );

    assign id_valid_o    = slot_q.valid;
    assign fetch_fault_o = slot_q.fault;
    assign id_instr_o    = slot_q.instr;
    assign id_pc_o       = slot_q.pc;
    assign id_pc_plus4_o = slot_q.pc_plus4;

`ifdef FETCH_PERF_EN
    logic [XLEN-1:0] fetch_cnt;
    logic [XLEN-1:0] stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (advance && in_range_p0) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
            if (stall_i && !redirect_valid_i) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end

    assign perf_fetch_count_o = fetch_cnt;
    assign perf_stall_count_o = stall_cnt;
`else
    logic unused_advance;
    assign unused_advance = advance;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
// Directed bench for fetch_stage with a behavioural reference model and a
// per-cycle compare process, plus literal expectations from the test plan.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        stall_i;
    logic        redirect_valid_i;
    logic [31:0] redirect_target_i;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_instr_i;
    logic        id_valid_o;
    logic [31:0] id_instr_o;
    logic [31:0] id_pc_o;
    logic [31:0] id_pc_plus4_o;
    logic        fetch_fault_o;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_count_o;
    logic [31:0] perf_stall_count_o;
`endif

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    logic [31:0] mem [0:255];

    fetch_stage dut (
        .clk              (clk),
        .rst              (rst),
        .stall_i          (stall_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_target_i(redirect_target_i),
        .imem_addr_o      (imem_addr_o),
        .imem_instr_i     (imem_instr_i),
        .id_valid_o       (id_valid_o),
        .id_instr_o       (id_instr_o),
        .id_pc_o          (id_pc_o),
        .id_pc_plus4_o    (id_pc_plus4_o),
`ifdef FETCH_PERF_EN
        .perf_fetch_count_o(perf_fetch_count_o),
        .perf_stall_count_o(perf_stall_count_o),
`endif
        .fetch_fault_o    (fetch_fault_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Asynchronous memory; out-of-range reads return junk that must never
    // reach a valid slot.
    always_comb begin
        if (imem_addr_o < 32'd1024) imem_instr_i = mem[imem_addr_o[9:2]];
        else                        imem_instr_i = 32'hBAD0_BAD0;
    end

    // ---------------- reference model ----------------
    logic [31:0] m_pc, m_instr, m_idpc, m_p4, m_fc, m_sc;
    logic        m_valid, m_fault;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pc <= 32'h0; m_valid <= 1'b0; m_instr <= 32'h33;
            m_idpc <= 32'h0; m_p4 <= 32'h0; m_fault <= 1'b0;
            m_fc <= 32'h0; m_sc <= 32'h0;
        end else if (redirect_valid_i) begin
            m_pc <= redirect_target_i & 32'hFFFF_FFFC;
            m_valid <= 1'b0; m_instr <= 32'h33; m_fault <= 1'b0;
        end else if (stall_i) begin
            m_sc <= m_sc + 1;
        end else begin
            m_pc   <= m_pc + 4;
            m_idpc <= m_pc;
            m_p4   <= m_pc + 4;
            if (m_pc < 1024) begin
                m_valid <= 1'b1; m_fault <= 1'b0;
                m_instr <= mem[m_pc / 4];
                m_fc    <= m_fc + 1;
            end else begin
                m_valid <= 1'b0; m_fault <= 1'b1; m_instr <= 32'h33;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk("model.addr",  imem_addr_o,           m_pc);
            chk("model.valid", {31'b0, id_valid_o},    {31'b0, m_valid});
            chk("model.instr", id_instr_o,            m_instr);
            chk("model.pc",    id_pc_o,               m_idpc);
            chk("model.pc4",   id_pc_plus4_o,         m_p4);
            chk("model.fault", {31'b0, fetch_fault_o}, {31'b0, m_fault});
`ifdef FETCH_PERF_EN
            chk("model.fcnt",  perf_fetch_count_o,    m_fc);
            chk("model.scnt",  perf_stall_count_o,    m_sc);
`endif
        end
    end

    task automatic step(input logic s, input logic r, input logic [31:0] t);
        stall_i = s;
        redirect_valid_i = r;
        redirect_target_i = t;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".addr"},  imem_addr_o,            32'h0);
        chk({tag, ".valid"}, {31'b0, id_valid_o},     32'h0);
        chk({tag, ".instr"}, id_instr_o,             32'h0000_0033);
        chk({tag, ".pc"},    id_pc_o,                32'h0);
        chk({tag, ".pc4"},   id_pc_plus4_o,          32'h0);
        chk({tag, ".fault"}, {31'b0, fetch_fault_o},  32'h0);
`ifdef FETCH_PERF_EN
        chk({tag, ".fcnt"},  perf_fetch_count_o,     32'h0);
        chk({tag, ".scnt"},  perf_stall_count_o,     32'h0);
`endif
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i;
        mem[1] = 32'h0010_80B3;
        rst = 1'b1;
        stall_i = 1'b0;
        redirect_valid_i = 1'b0;
        redirect_target_i = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        rst = 1'b0;
        chk_en = 1'b1;

        // Sequential fetch from reset PC
        step(0, 0, 0);
        chk("seq0.pc",    id_pc_o,               32'h0);
        chk("seq0.valid", {31'b0, id_valid_o},    32'h1);
        chk("seq0.instr", id_instr_o,            32'h1000_0000);
        step(0, 0, 0);
        chk("seq1.pc",    id_pc_o,               32'h4);
        chk("seq1.instr", id_instr_o,            32'h0010_80B3);
        chk("seq1.pc4",   id_pc_plus4_o,         32'h8);
        step(0, 0, 0);
        chk("seq2.addr",  imem_addr_o,           32'h0C);

        // Stall three cycles at PC=0x0C
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0);
            chk("stall.addr", imem_addr_o, 32'h0C);
            chk("stall.pc",   id_pc_o,     32'h08);
        end
        step(0, 0, 0);
        chk("unstall.pc", id_pc_o, 32'h0C);

        // Redirect overrides stall, low target bits dropped
        step(1, 1, 32'h23);
        chk("redir.addr",  imem_addr_o,         32'h20);
        chk("redir.valid", {31'b0, id_valid_o},  32'h0);
        chk("redir.instr", id_instr_o,          32'h33);
        step(0, 0, 0);
        chk("redir1.pc",    id_pc_o,             32'h20);
        chk("redir1.valid", {31'b0, id_valid_o},  32'h1);

        // Edge of instruction memory
        step(0, 1, 32'h3FC);
        step(0, 0, 0);
        chk("edge.pc",    id_pc_o,                32'h3FC);
        chk("edge.valid", {31'b0, id_valid_o},     32'h1);
        chk("edge.instr", id_instr_o,             32'h1000_00FF);
        step(0, 0, 0);
        chk("oob.pc",    id_pc_o,                 32'h400);
        chk("oob.valid", {31'b0, id_valid_o},      32'h0);
        chk("oob.fault", {31'b0, fetch_fault_o},   32'h1);
        chk("oob.instr", id_instr_o,              32'h33);

        // 32-bit wrap
        step(0, 1, 32'hFFFF_FFFC);
        step(0, 0, 0);
        chk("wrap.pc",    id_pc_o,                32'hFFFF_FFFC);
        chk("wrap.pc4",   id_pc_plus4_o,          32'h0);
        chk("wrap.addr",  imem_addr_o,            32'h0);
        chk("wrap.fault", {31'b0, fetch_fault_o},  32'h1);
        step(0, 0, 0);
        chk("wrap1.valid", {31'b0, id_valid_o},   32'h1);
        step(1, 0, 0);
        step(0, 0, 0);

        // Asynchronous reset between edges, with stall and redirect held high
        stall_i = 1'b1;
        redirect_valid_i = 1'b1;
        redirect_target_i = 32'h100;
        #1 rst = 1'b1;
        #1 chk_reset_vals("async");
        #1 rst = 1'b0;
        step(0, 0, 0);
        chk("post.pc",    id_pc_o,             32'h0);
        chk("post.valid", {31'b0, id_valid_o},  32'h1);
        repeat (3) step(0, 0, 0);

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
